// File: rtl/syncfifo_plus_if.sv
// Handshake, data and status bundle of the synchronous FIFO.
interface syncfifo_plus_if #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 4
) ();

  logic              clr;
  logic              wren;
  logic              rden;
  logic [DWIDTH-1:0] din;
  logic [DWIDTH-1:0] dout;
  logic              full;
  logic              empty;
  logic              afull;
  logic              aempty;
  logic [AWIDTH:0]   count;
  logic              overflow;
  logic              underflow;

  // Producer/consumer side: drives requests, observes data and status.
  modport master (
    output clr, wren, rden, din,
    input  dout, full, empty, afull, aempty, count, overflow, underflow
  );

  // FIFO side.
  modport slave (
    input  clr, wren, rden, din,
    output dout, full, empty, afull, aempty, count, overflow, underflow
  );

endinterface

// File: rtl/syncfifo_plus.sv
// Synchronous FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and registered or fall-through read data.
module syncfifo_plus #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 4,
  parameter int unsigned AF_LVL = (2 ** AWIDTH) - 2,
  parameter int unsigned AE_LVL = 2,
  parameter int unsigned FWFT   = 0
) (
  input logic           clk,
  input logic           rstn,
  syncfifo_plus_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** AWIDTH;
  localparam int unsigned CW    = AWIDTH + 1;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [AWIDTH-1:0] wptr, rptr, wptr_nxt, rptr_nxt;
  logic [CW-1:0]     count, count_nxt;
  logic [DWIDTH-1:0] dout, dout_nxt;
  logic              full, empty, afull, aempty;
  logic              overflow, underflow, overflow_nxt, underflow_nxt;
  logic              wr_acc, rd_acc;

  // Acceptance, pointer/count update, sticky errors and next read word.
  always_comb begin
    wr_acc        = bus.wren & ~full  & ~bus.clr;
    rd_acc        = bus.rden & ~empty & ~bus.clr;
    wptr_nxt      = wptr;
    rptr_nxt      = rptr;
    count_nxt     = count;
    overflow_nxt  = overflow  | (bus.wren & full);
    underflow_nxt = underflow | (bus.rden & empty);
    dout_nxt      = dout;

    if (wr_acc) wptr_nxt = wptr + AWIDTH'(1);
    if (rd_acc) rptr_nxt = rptr + AWIDTH'(1);

    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase

    if (bus.clr) begin
      wptr_nxt      = '0;
      rptr_nxt      = '0;
      count_nxt     = '0;
      overflow_nxt  = 1'b0;
      underflow_nxt = 1'b0;
    end else if (FWFT != 0) begin
      // Fall-through: register the next head word; a write landing on the
      // new head slot this cycle is not yet in memory, so take it from din.
      if (wr_acc && (wptr == rptr_nxt)) dout_nxt = bus.din;
      else                              dout_nxt = mem[rptr_nxt];
    end else if (rd_acc) begin
      dout_nxt = mem[rptr];
    end
  end

  // Control state and registered status flags decoded from next count.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      dout      <= '0;
      empty     <= 1'b1;
      aempty    <= 1'b1;
      full      <= 1'b0;
      afull     <= 1'b0;
    end else begin
      wptr      <= wptr_nxt;
      rptr      <= rptr_nxt;
      count     <= count_nxt;
      overflow  <= overflow_nxt;
      underflow <= underflow_nxt;
      dout      <= dout_nxt;
      empty     <= (count_nxt == '0);
      full      <= (count_nxt == CW'(DEPTH));
      afull     <= (count_nxt >= CW'(AF_LVL));
      aempty    <= (count_nxt <= CW'(AE_LVL));
    end
  end

  // Storage array; contents survive reset and flush.
  always_ff @(posedge clk) begin
    if (rstn && wr_acc) mem[wptr] <= bus.din;
  end

  assign bus.dout      = dout;
  assign bus.count     = count;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.afull     = afull;
  assign bus.aempty    = aempty;
  assign bus.overflow  = overflow;
  assign bus.underflow = underflow;

endmodule

// File: tb/tb_syncfifo_plus.sv
// Scoreboard bench for syncfifo_plus: one registered-read and one
// fall-through instance, DEPTH=4, AF_LVL=3, AE_LVL=1.
module tb_syncfifo_plus;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       pend0 = 1'b0;

  syncfifo_plus_if #(.DWIDTH(8), .AWIDTH(2)) f0 ();
  syncfifo_plus_if #(.DWIDTH(8), .AWIDTH(2)) f1 ();

  syncfifo_plus #(.DWIDTH(8), .AWIDTH(2), .AF_LVL(3), .AE_LVL(1), .FWFT(0))
    u0 (.clk(clk), .rstn(rstn), .bus(f0.slave));
  syncfifo_plus #(.DWIDTH(8), .AWIDTH(2), .AF_LVL(3), .AE_LVL(1), .FWFT(1))
    u1 (.clk(clk), .rstn(rstn), .bus(f1.slave));

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Registered-read monitor: a read accepted at this edge yields data next.
  always @(posedge clk) pend0 = rstn && f0.rden && !f0.empty && !f0.clr;

  always @(negedge clk) begin
    if (pend0) begin
      if (q0.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL rd0_unexpected: got %0h expected no data", f0.dout);
      end else begin
        check("rd0_data", int'(f0.dout), int'(q0.pop_front()));
      end
    end
  end

  // Fall-through monitor: the word on dout is consumed at the read edge.
  always @(posedge clk) begin
    if (rstn && f1.rden && !f1.empty && !f1.clr) begin
      if (q1.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL rd1_unexpected: got %0h expected no data", f1.dout);
      end else begin
        check("rd1_data", int'(f1.dout), int'(q1.pop_front()));
      end
    end
  end

  task automatic c0(input logic w, input logic r, input logic [7:0] d, input logic c);
    f0.wren = w; f0.rden = r; f0.din = d; f0.clr = c;
    @(posedge clk); @(negedge clk); #1;
    f0.wren = 1'b0; f0.rden = 1'b0; f0.clr = 1'b0;
  endtask

  task automatic c1(input logic w, input logic r, input logic [7:0] d);
    f1.wren = w; f1.rden = r; f1.din = d; f1.clr = 1'b0;
    @(posedge clk); @(negedge clk); #1;
    f1.wren = 1'b0; f1.rden = 1'b0;
  endtask

  task automatic st0(input string tag, input int cnt, input int e, input int f,
                     input int ae, input int af);
    check({tag, "_count"},  int'(f0.count),  cnt);
    check({tag, "_empty"},  int'(f0.empty),  e);
    check({tag, "_full"},   int'(f0.full),   f);
    check({tag, "_aempty"}, int'(f0.aempty), ae);
    check({tag, "_afull"},  int'(f0.afull),  af);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] wv [4];
    logic [7:0] av [6];
    int         cn [4];
    wv = '{8'h11, 8'h22, 8'h33, 8'h44};
    av = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    cn = '{1, 2, 3, 4};

    f0.wren = 0; f0.rden = 0; f0.din = 0; f0.clr = 0;
    f1.wren = 0; f1.rden = 0; f1.din = 0; f1.clr = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    st0("rst", 0, 1, 0, 1, 0);
    check("rst_ovf",  int'(f0.overflow),  0);
    check("rst_ufl",  int'(f0.underflow), 0);
    check("rst_dout", int'(f0.dout),      0);
    rstn = 1'b1;

    // Fill to full, checking thresholds at each level.
    for (int i = 0; i < 4; i++) begin
      q0.push_back(wv[i]);
      c0(1, 0, wv[i], 0);
      st0($sformatf("fill%0d", i), cn[i], 0, (i == 3) ? 1 : 0,
          (i == 0) ? 1 : 0, (i >= 2) ? 1 : 0);
    end

    // Full with write+read: only the read is taken, write is dropped.
    c0(1, 1, 8'h55, 0);
    st0("ovf", 3, 0, 0, 0, 1);
    check("ovf_flag", int'(f0.overflow), 1);
    for (int i = 0; i < 3; i++) c0(0, 1, 8'h00, 0);
    st0("drain", 0, 1, 0, 1, 0);
    check("ovf_sticky", int'(f0.overflow), 1);

    // Empty with write+read: only the write is taken.
    q0.push_back(8'h66);
    c0(1, 1, 8'h66, 0);
    st0("ufl", 1, 0, 0, 1, 0);
    check("ufl_flag", int'(f0.underflow), 1);
    c0(0, 1, 8'h00, 0);
    check("ufl_cnt", int'(f0.count), 0);

    // Flush clears errors and keeps dout.
    c0(0, 0, 8'h00, 1);
    check("clr_ovf",  int'(f0.overflow),  0);
    check("clr_ufl",  int'(f0.underflow), 0);
    check("clr_dout", int'(f0.dout),      8'h66);

    // Steady-state write+read at count 2 across pointer wrap.
    q0.push_back(8'h01); c0(1, 0, 8'h01, 0);
    q0.push_back(8'h02); c0(1, 0, 8'h02, 0);
    for (int i = 0; i < 6; i++) begin
      q0.push_back(av[i]);
      c0(1, 1, av[i], 0);
      check($sformatf("wrap%0d_count", i), int'(f0.count), 2);
    end
    c0(0, 1, 8'h00, 0);
    c0(0, 1, 8'h00, 0);
    st0("wrapend", 0, 1, 0, 1, 0);

    // Overflow at count 3, then flush with a concurrent write.
    for (int i = 0; i < 4; i++) begin
      q0.push_back(8'hB1 + 8'(i));
      c0(1, 0, 8'hB1 + 8'(i), 0);
    end
    c0(1, 0, 8'hBF, 0);
    c0(0, 1, 8'h00, 0);
    check("pre_clr_count", int'(f0.count), 3);
    check("pre_clr_ovf",   int'(f0.overflow), 1);
    q0.delete();
    c0(1, 0, 8'hCC, 1);
    st0("clrw", 0, 1, 0, 1, 0);
    check("clrw_ovf", int'(f0.overflow), 0);

    // Reset mid-stream discards contents.
    q0.push_back(8'hD1); c0(1, 0, 8'hD1, 0);
    q0.push_back(8'hD2); c0(1, 0, 8'hD2, 0);
    rstn = 1'b0;
    c0(1, 0, 8'hEE, 0);
    st0("mrst", 0, 1, 0, 1, 0);
    check("mrst_ovf",  int'(f0.overflow),  0);
    check("mrst_ufl",  int'(f0.underflow), 0);
    check("mrst_dout", int'(f0.dout),      0);
    q0.delete();
    rstn = 1'b1;
    q0.push_back(8'hF1);
    c0(1, 0, 8'hF1, 0);
    check("post_rst_count", int'(f0.count), 1);
    c0(0, 1, 8'h00, 0);
    c0(0, 0, 8'h00, 0);

    // Fall-through instance.
    q1.push_back(8'h77);
    c1(1, 0, 8'h77);
    check("fw_dout",  int'(f1.dout),  8'h77);
    check("fw_empty", int'(f1.empty), 0);
    c1(0, 1, 8'h00);
    check("fw_rd_empty", int'(f1.empty), 1);
    q1.push_back(8'h81);
    c1(1, 0, 8'h81);
    q1.push_back(8'h82);
    c1(1, 1, 8'h82);
    check("fw_byp_count", int'(f1.count), 1);
    check("fw_byp_dout",  int'(f1.dout),  8'h82);
    c1(0, 1, 8'h00);
    check("fw_end_empty", int'(f1.empty), 1);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
